// File: rtl/trdb_pkg.sv
// Shared types, default sizes and index helpers for the trdb trace arbiters.
package trdb_pkg;

  typedef enum logic [0:0] {IDLE, LOCKED} arb_state_t;

  localparam int TRDB_NUM_SRC    = 4;
  localparam int TRDB_PKT_DATA_W = 32;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/trdb_rr_pick.sv
// Combinational round-robin pick: first valid index at or above rr_ptr, with wrap.
// Zero latency; no flow control of its own.
module trdb_rr_pick #(
  parameter int NUM_SRC = trdb_pkg::TRDB_NUM_SRC,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_SRC);

  logic [IDX_W:0] sum;

  // Walk offsets from farthest to nearest so the nearest valid source wins.
  always_comb begin
    winner    = '0;
    sum       = '0;
    any_valid = |valid;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      if (valid[sum[IDX_W-1:0]]) winner = sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/trdb_packet_arbiter.sv
// Packet-granular round-robin mux onto one registered output; 1-cycle latency, ready = output slot free.
// Define TRDB_ARB_PRIO_EN to give source 0 strict priority whenever the arbiter is idle.
module trdb_packet_arbiter
  import trdb_pkg::*;
#(
  parameter int NUM_SRC = TRDB_NUM_SRC,
  parameter int DATA_W  = TRDB_PKT_DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data_i,
  input  logic [NUM_SRC-1:0]         src_last_i,
  output logic [NUM_SRC-1:0]         src_ready_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_last_o,
  output logic [$clog2(NUM_SRC)-1:0] out_src_o,
  input  logic                       out_ready_i,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic [CNT_W-1:0]           pkt_cnt_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_winner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cur_idx;
  logic             any_valid;
  logic             can_load;
  logic             cur_vld;
  logic             xfer;
  logic             upd_rr;

  trdb_rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick (
    .valid     (src_valid_i),
    .rr_ptr    (rr_ptr),
    .winner    (rr_winner),
    .any_valid (any_valid)
  );

`ifdef TRDB_ARB_PRIO_EN
  assign winner = src_valid_i[0] ? '0 : rr_winner;
  // Source 0 rides outside the rotation, so completing its packet leaves rr_ptr alone.
  assign upd_rr = (cur_idx != '0);
`else
  assign winner = rr_winner;
  assign upd_rr = 1'b1;
`endif

  assign can_load = !out_valid_o || out_ready_i;
  assign cur_idx  = (state == LOCKED) ? grant_idx : winner;
  assign cur_vld  = (state == LOCKED) ? src_valid_i[grant_idx] : any_valid;
  assign xfer     = cur_vld && can_load && !flush_i && !rst;
  assign busy_o   = (state == LOCKED) || out_valid_o;

  always_comb begin
    src_ready_o = '0;
    if (!rst && !flush_i && (state == LOCKED || any_valid))
      src_ready_o[cur_idx] = can_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
      out_src_o   <= '0;
      pkt_cnt_o   <= '0;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      state       <= IDLE;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      rr_ptr      <= '0;
      state       <= IDLE;
    end else begin
      if (out_valid_o && out_ready_i && out_last_o && (pkt_cnt_o != '1))
        pkt_cnt_o <= pkt_cnt_o + 1'b1;

      if (xfer) begin
        out_valid_o <= 1'b1;
        out_data_o  <= src_data_i[int'(cur_idx)*DATA_W +: DATA_W];
        out_last_o  <= src_last_i[cur_idx];
        out_src_o   <= cur_idx;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      if (xfer) begin
        if (src_last_i[cur_idx]) begin
          state <= IDLE;
          if (upd_rr) rr_ptr <= IDX_W'(next_idx(int'(cur_idx), NUM_SRC));
        end else if (state == IDLE) begin
          grant_idx <= cur_idx;
          state     <= LOCKED;
        end
      end
    end
  end

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Directed-vector bench for trdb_packet_arbiter (4 sources, 32-bit beats, 4-bit counter).
module tb_trdb_packet_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_valid_i;
  logic [NS*DW-1:0] src_data_i;
  logic [NS-1:0]    src_last_i;
  logic [NS-1:0]    src_ready_o;
  logic             out_valid_o;
  logic [DW-1:0]    out_data_o;
  logic             out_last_o;
  logic [1:0]       out_src_o;
  logic             out_ready_i;
  logic             flush_i;
  logic             busy_o;
  logic [CW-1:0]    pkt_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  trdb_packet_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid_i (src_valid_i),
    .src_data_i  (src_data_i),
    .src_last_i  (src_last_i),
    .src_ready_o (src_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_src_o   (out_src_o),
    .out_ready_i (out_ready_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .pkt_cnt_o   (pkt_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic v, input logic [DW-1:0] d, input logic l);
    src_valid_i[k]          = v;
    src_data_i[k*DW +: DW]  = d;
    src_last_i[k]           = l;
  endtask

  task automatic do_reset();
    src_valid_i = '0;
    src_data_i  = '0;
    src_last_i  = '0;
    out_ready_i = 1'b1;
    flush_i     = 1'b0;
    rst         = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    src_valid_i = '1;
    #1;
    n_vec++; if (src_ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", src_ready_o); end
    n_vec++; if ({out_valid_o, out_last_o, out_src_o, out_data_o} !== '0) begin n_err++; $display("FAIL reset_out got=%b/%b/%0d/%h exp=0", out_valid_o, out_last_o, out_src_o, out_data_o); end
    n_vec++; if (pkt_cnt_o !== 4'd0 || busy_o !== 1'b0) begin n_err++; $display("FAIL reset_cnt_busy got=%0d/%b exp=0/0", pkt_cnt_o, busy_o); end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int k = 0; k < NS; k++) set_src(k, 1'b1, 32'h10 + k, 1'b1);
    #1;
    n_vec++; if (src_ready_o !== 4'b0001) begin n_err++; $display("FAIL rr_first_ready got=%b exp=0001", src_ready_o); end
    n_vec++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL rr_latency got=%b exp=0", out_valid_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (out_valid_o !== 1'b1 || out_src_o !== exp_src[i] || out_data_o !== 32'h10 + exp_src[i]) begin
        n_err++; $display("FAIL rr_seq[%0d] got v=%b src=%0d data=%h exp src=%0d", i, out_valid_o, out_src_o, out_data_o, exp_src[i]);
      end
    end
    src_valid_i = '0;
    tick();
    n_vec++; if (pkt_cnt_o !== 4'd5 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL rr_cnt got=%0d v=%b exp=5 v=0", pkt_cnt_o, out_valid_o); end
  endtask

  task automatic test_locked();
    logic [DW-1:0] exp_d[4] = '{32'hA1, 32'hA2, 32'hA3, 32'hB2};
    do_reset();
    set_src(1, 1'b1, 32'hA1, 1'b0);
    set_src(2, 1'b1, 32'hB2, 1'b1);
    #1;
    n_vec++; if (src_ready_o !== 4'b0010) begin n_err++; $display("FAIL lock_first_ready got=%b exp=0010", src_ready_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_d[i] || out_src_o !== ((i < 3) ? 2'd1 : 2'd2)) begin
        n_err++; $display("FAIL lock_beat[%0d] got data=%h src=%0d exp data=%h", i, out_data_o, out_src_o, exp_d[i]);
      end
      if (i == 0) set_src(1, 1'b1, 32'hA2, 1'b0);
      if (i == 1) set_src(1, 1'b1, 32'hA3, 1'b1);
      if (i == 2) set_src(1, 1'b0, 32'h0, 1'b0);
      #1;
      if (i < 2) begin
        n_vec++; if (src_ready_o !== 4'b0010 || busy_o !== 1'b1) begin n_err++; $display("FAIL lock_hold_ready[%0d] got=%b busy=%b exp=0010 busy=1", i, src_ready_o, busy_o); end
      end
      if (i == 2) begin
        n_vec++; if (src_ready_o !== 4'b0100) begin n_err++; $display("FAIL lock_release_ready got=%b exp=0100", src_ready_o); end
        set_src(2, 1'b1, 32'hB2, 1'b1);
      end
      if (i == 3) src_valid_i = '0;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(0, 1'b1, 32'h55, 1'b1);
    tick();
    set_src(0, 1'b1, 32'h66, 1'b1);
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (out_data_o !== 32'h55 || out_valid_o !== 1'b1 || src_ready_o !== 4'b0000) begin
        n_err++; $display("FAIL bp_hold[%0d] got data=%h v=%b ready=%b exp 55/1/0000", i, out_data_o, out_valid_o, src_ready_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    n_vec++; if (src_ready_o !== 4'b0001) begin n_err++; $display("FAIL bp_release_ready got=%b exp=0001", src_ready_o); end
    tick();
    src_valid_i = '0;
    n_vec++; if (out_data_o !== 32'h66 || pkt_cnt_o !== 4'd1) begin n_err++; $display("FAIL bp_next got data=%h cnt=%0d exp 66/1", out_data_o, pkt_cnt_o); end
    tick();
    n_vec++; if (pkt_cnt_o !== 4'd2 || out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain got cnt=%0d v=%b exp 2/0", pkt_cnt_o, out_valid_o); end
  endtask

  task automatic test_flush();
    do_reset();
    set_src(2, 1'b1, 32'hD2, 1'b1);
    tick();
    set_src(2, 1'b0, 32'h0, 1'b0);
    set_src(3, 1'b1, 32'hC1, 1'b0);
    tick();
    set_src(3, 1'b1, 32'hC2, 1'b0);
    tick();
    n_vec++; if (out_data_o !== 32'hC2 || busy_o !== 1'b1 || pkt_cnt_o !== 4'd1) begin n_err++; $display("FAIL flush_pre got data=%h busy=%b cnt=%0d exp C2/1/1", out_data_o, busy_o, pkt_cnt_o); end
    flush_i = 1'b1;
    set_src(3, 1'b1, 32'hC3, 1'b0);
    #1;
    n_vec++; if (src_ready_o !== 4'b0000) begin n_err++; $display("FAIL flush_ready got=%b exp=0000", src_ready_o); end
    tick();
    flush_i = 1'b0;
    n_vec++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || pkt_cnt_o !== 4'd1) begin n_err++; $display("FAIL flush_after got v=%b busy=%b cnt=%0d exp 0/0/1", out_valid_o, busy_o, pkt_cnt_o); end
    set_src(1, 1'b1, 32'hE1, 1'b1);
    set_src(3, 1'b1, 32'hC3, 1'b1);
    #1;
    n_vec++; if (src_ready_o !== 4'b0010) begin n_err++; $display("FAIL flush_regrant got=%b exp=0010", src_ready_o); end
    tick();
    src_valid_i = '0;
    n_vec++; if (out_src_o !== 2'd1 || out_data_o !== 32'hE1) begin n_err++; $display("FAIL flush_out got src=%0d data=%h exp 1/E1", out_src_o, out_data_o); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_src(0, 1'b1, 32'h77, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 10) begin
        n_vec++; if (pkt_cnt_o !== 4'd10) begin n_err++; $display("FAIL sat_mid got=%0d exp=10", pkt_cnt_o); end
      end
    end
    src_valid_i = '0;
    tick();
    tick();
    n_vec++; if (pkt_cnt_o !== 4'd15) begin n_err++; $display("FAIL sat_final got=%0d exp=15", pkt_cnt_o); end
  endtask

  task automatic test_priority();
`ifdef TRDB_ARB_PRIO_EN
    logic [1:0] exp_src[4] = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    logic [1:0] exp_src[4] = '{2'd0, 2'd2, 2'd0, 2'd2};
`endif
    do_reset();
    set_src(0, 1'b1, 32'h90, 1'b1);
    set_src(2, 1'b1, 32'h92, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++; if (out_src_o !== exp_src[i]) begin n_err++; $display("FAIL prio_seq[%0d] got=%0d exp=%0d", i, out_src_o, exp_src[i]); end
    end
    set_src(0, 1'b0, 32'h0, 1'b0);
    tick();
    n_vec++; if (out_src_o !== 2'd2 || out_data_o !== 32'h92) begin n_err++; $display("FAIL prio_other got src=%0d data=%h exp 2/92", out_src_o, out_data_o); end
    src_valid_i = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_src(1, 1'b1, 32'hF1, 1'b0);
    tick();
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%b exp=1", busy_o); end
    rst = 1'b1;
    #1;
    n_vec++; if (src_ready_o !== 4'b0000 || out_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL rstmid got ready=%b v=%b busy=%b exp 0000/0/0", src_ready_o, out_valid_o, busy_o); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_locked();
    test_backpressure();
    test_flush();
    test_saturation();
    test_priority();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
